display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display. It holds a tear-free shadow copy of NUM_DIGITS BCD digits and steps one digit at a time through the shared BCD-to-segment decoder. For each digit it drives one-hot digit enables, with a dead-time blank between digits to prevent ghosting. It sits between the application logic, which loads values, and the display pins.

## Interface
- NUM_DIGITS, 4: digits scanned; ≥2.
- SHOW_CYC, 1000: clocks each digit is lit; ≥1.
- BLANK_CYC, 16: dead-time clocks between digits; ≥1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- load  in  1  single-cycle request to capture bcd_in/dp_in.
- bcd_in  in  4*NUM_DIGITS  digit k = bcd_in[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- blank_lz  in  1  enable leading-zero blanking; sampled continuously.
- load_ack  out  1  one-cycle pulse when a pending load is committed to the display.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- digit_en  out  NUM_DIGITS  one-hot active-high digit select; all zero during blank.
- seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, active-high; bit 0 is dp.

## Operation
- Registers:
  - active[] and active_dp[]: the displayed value.
  - pending[] and pending_dp[] with a pend flag.
  - idx: the current digit.
  - cnt: cycle counter.
  - state ∈ {BLANK, SHOW}.
- Reset values:
  - active = pending = 0; pend = 0; idx = 0; cnt = 0; state = BLANK.
  - All outputs 0.
- BLANK:
  - digit_en = 0, seg_out = 0.
  - After BLANK_CYC cycles, transition to SHOW.
- SHOW:
  - digit_en = 1<<idx.
  - seg_out is captured on the entry edge and held for the whole slot.
  - After SHOW_CYC cycles, transition to BLANK.
  - On that transition idx increments, wrapping NUM_DIGITS-1 → 0.
- Wrap edge (SHOW of the last digit → BLANK):
  - frame_done pulses.
  - If pend = 1: active ← pending, pend ← 0, load_ack pulses on the same edge.
- Load: on load=1, pending ← bcd_in/dp_in and pend ← 1. Data is never applied mid-frame.
- Repeated loads before a commit: the latest wins; exactly one load_ack.
- load asserted on the commit edge:
  - The previous pending value commits.
  - The new value becomes pending; pend stays 1.
- Segment value for digit idx:
  - The decoder is fed active[idx].
  - Codes 10–15 force seg_out = 0 (the decoder is not consulted for them), dp included.
  - Otherwise seg_out = {decoder[7:1], active_dp[idx]}.
- Leading-zero blanking:
  - When blank_lz=1, each zero digit above the highest nonzero digit shows seg_out = 0, dp included.
  - Digit 0 is never blanked.
  - The blanking mask is computed from active.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- After rst_n deasserts, digit 0 lights at edge BLANK_CYC.
- Slot period: SHOW_CYC + BLANK_CYC.
- Frame period: NUM_DIGITS × (SHOW_CYC + BLANK_CYC).
- A load becomes visible at the first SHOW of digit 0 after the next frame_done.
  - Worst case it appears after one frame + BLANK_CYC.
- Asynchronous reset mid-SHOW:
  - digit_en and seg_out go to 0 immediately.
  - The pending load is discarded; no ack.

## Structure
- Shared package display_pkg:
  - State enum {BLANK, SHOW}.
  - SEG_BLANK = 8'h00.
  - BCD_MAX = 9.
  - Segment bit-position constants.
- One sub-module: the existing `decoder` (4-bit BCD → 8-bit segments), instantiated once.
  - It is fed from the active digit mux.
  - Its output is masked and registered by this block.

## Test plan
Parameters for all cases: NUM_DIGITS=4, SHOW_CYC=4, BLANK_CYC=2.
- Reset, then idle 30 cycles with blank_lz=0:
  - All outputs 0 during reset.
  - Then digit_en cycles 0001, 0010, 0100, 1000, each for 4 cycles, separated by 2 zero cycles.
  - seg_out = 8'hFC in every slot.
  - frame_done fires every 24 cycles.
- Load bcd_in=16'h1234, dp_in=4'b0100:
  - load_ack occurs at the next frame_done.
  - Next frame shows digit0 = 8'h66, digit1 = 8'hF2, digit2 = 8'hDB (dp set), digit3 = 8'h60.
- Load 16'h0007 with blank_lz=1:
  - Digits 3–1 show seg_out = 0 with digit_en still asserted; digit 0 shows 8'hE4.
  - Setting blank_lz=0 makes digits 3–1 show 8'hFC.
- Load 16'h00A5:
  - digit1 (code 0xA) shows 8'h00; digit0 shows 8'hB6.
- Load 16'h1111 then 16'h2222 in the same frame, with a third load on the commit edge:
  - One load_ack; the display shows 2222.
  - The third value commits one frame later.
- Assert rst_n=0 mid-SHOW of digit 2 with a load pending:
  - Outputs are 0 immediately.
  - After release, the display shows 0000 with no load_ack.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
// Segment byte layout is {a,b,c,d,e,f,g,dp}, active-high.
package display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Non-BCD codes and blanked leading zeros go dark entirely, decimal point included.
   function automatic logic [7:0] seg_select(
      input logic [7:0] dec,
      input logic [3:0] bcd,
      input logic       dp,
      input logic       lz_blank
   );
      logic [7:0] seg;
      seg = SEG_BLANK;
      if ((bcd > BCD_MAX) || lz_blank) begin
         seg = SEG_BLANK;
      end else begin
         seg         = dec;
         seg[SEG_DP] = dp;
      end
      return seg;
   endfunction

endpackage

// File: rtl/decoder.sv
// BCD to 7-segment decoder; the dp bit is always low and codes above 9 decode to dark.
module decoder
   import display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [7:0] seg_o
);

   logic [6:0] abcdefg;

   // Segment pattern lookup, then placement into the shared segment byte layout
   always_comb begin
      case (bcd_i)
         4'd0:    abcdefg = 7'b1111110;
         4'd1:    abcdefg = 7'b0110000;
         4'd2:    abcdefg = 7'b1101101;
         4'd3:    abcdefg = 7'b1111001;
         4'd4:    abcdefg = 7'b0110011;
         4'd5:    abcdefg = 7'b1011011;
         4'd6:    abcdefg = 7'b1011111;
         4'd7:    abcdefg = 7'b1110010;
         4'd8:    abcdefg = 7'b1111111;
         4'd9:    abcdefg = 7'b1111011;
         default: abcdefg = 7'b0000000;
      endcase
      seg_o        = SEG_BLANK;
      seg_o[SEG_A] = abcdefg[6];
      seg_o[SEG_B] = abcdefg[5];
      seg_o[SEG_C] = abcdefg[4];
      seg_o[SEG_D] = abcdefg[3];
      seg_o[SEG_E] = abcdefg[2];
      seg_o[SEG_F] = abcdefg[1];
      seg_o[SEG_G] = abcdefg[0];
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// New digit values are held pending and committed only at the frame wrap, so a frame never tears.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SHOW_CYC   = 1000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic                    load_ack,
   output logic                    frame_done,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic [7:0]              seg_out
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

   scan_state_e               state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [IDX_W-1:0]          idx_q;
   logic [4*NUM_DIGITS-1:0]   active_q;
   logic [NUM_DIGITS-1:0]     active_dp_q;
   logic [4*NUM_DIGITS-1:0]   pending_q;
   logic [NUM_DIGITS-1:0]     pending_dp_q;
   logic                      pend_q;
   logic [NUM_DIGITS-1:0]     digit_en_q;
   logic [7:0]                seg_q;
   logic                      load_ack_q;
   logic                      frame_done_q;

   logic [3:0]                cur_bcd;
   logic                      cur_dp;
   logic [7:0]                dec_seg;
   logic [7:0]                seg_d;
   logic [IDX_W-1:0]          idx_d;
   logic                      show_end;
   logic                      blank_end;
   logic                      frame_end;
   logic [NUM_DIGITS-1:0]     lz_mask;
   logic                      zero_above;

   decoder u_decoder (
      .bcd_i (cur_bcd),
      .seg_o (dec_seg)
   );

   // Leading-zero mask: a digit is blankable when it and every digit above it are zero
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above && (active_q[4*k +: 4] == 4'd0);
         lz_mask[k] = zero_above;
      end
   end

   // Digit mux, slot-end detection and the segment byte latched on slot entry
   always_comb begin
      cur_bcd   = active_q[{idx_q, 2'b00} +: 4];
      cur_dp    = active_dp_q[idx_q];
      show_end  = (state_q == SHOW) && (cnt_q == SHOW_LAST);
      blank_end = (state_q == BLANK) && (cnt_q == BLANK_LAST);
      frame_end = show_end && (idx_q == LAST_IDX);
      idx_d     = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
      seg_d     = seg_select(dec_seg, cur_bcd, cur_dp, blank_lz && lz_mask[idx_q]);
   end

   // Scan FSM with registered digit enables, segments and frame pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         digit_en_q   <= '0;
         seg_q        <= SEG_BLANK;
         frame_done_q <= 1'b0;
         load_ack_q   <= 1'b0;
      end else begin
         frame_done_q <= frame_end;
         load_ack_q   <= frame_end && pend_q;
         case (state_q)
            BLANK: begin
               if (blank_end) begin
                  state_q    <= SHOW;
                  cnt_q      <= '0;
                  digit_en_q <= NUM_DIGITS'(1) << idx_q;
                  seg_q      <= seg_d;
               end else begin
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end
            SHOW: begin
               if (show_end) begin
                  state_q    <= BLANK;
                  cnt_q      <= '0;
                  idx_q      <= idx_d;
                  digit_en_q <= '0;
                  seg_q      <= SEG_BLANK;
               end else begin
                  cnt_q      <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q    <= BLANK;
               cnt_q      <= '0;
               digit_en_q <= '0;
               seg_q      <= SEG_BLANK;
            end
         endcase
      end
   end

   // Shadow registers: loads land in pending, which moves to active only at the frame wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q     <= '0;
         active_dp_q  <= '0;
         pending_q    <= '0;
         pending_dp_q <= '0;
         pend_q       <= 1'b0;
      end else begin
         if (frame_end && pend_q) begin
            active_q    <= pending_q;
            active_dp_q <= pending_dp_q;
         end
         if (load) begin
            pending_q    <= bcd_in;
            pending_dp_q <= dp_in;
            pend_q       <= 1'b1;
         end else if (frame_end) begin
            pend_q       <= 1'b0;
         end
      end
   end

   assign load_ack   = load_ack_q;
   assign frame_done = frame_done_q;
   assign digit_en   = digit_en_q;
   assign seg_out    = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with NUM_DIGITS=4, SHOW_CYC=4, BLANK_CYC=2.
// Frame samples are packed as {digit_en, seg_out, frame_done, load_ack} and taken at the falling edge.
module tb_display_scan_ctrl;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] bcd_in   = 16'h0000;
   logic [3:0]  dp_in    = 4'b0000;
   logic        load_ack;
   logic        frame_done;
   logic [3:0]  digit_en;
   logic [7:0]  seg_out;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [13:0] cap [1:24];

   display_scan_ctrl #(
      .NUM_DIGITS (4),
      .SHOW_CYC   (4),
      .BLANK_CYC  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .load_ack   (load_ack),
      .frame_done (frame_done),
      .digit_en   (digit_en),
      .seg_out    (seg_out)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Sample i (1..24) is taken after the i-th edge following a frame wrap; slots are 2 blank + 4 lit.
   function automatic logic [13:0] frame_exp(input int i, input logic [31:0] segs, input logic ack_end);
      int         d;
      int         off;
      logic [3:0] en;
      logic [7:0] sg;
      d   = (i - 1) / 6;
      off = i - 6 * d;
      if (off >= 2 && off <= 5) begin
         en = 4'b0001 << d;
         sg = segs[8*d +: 8];
      end else begin
         en = 4'b0000;
         sg = 8'h00;
      end
      return {en, sg, (i == 24), ((i == 24) && ack_end)};
   endfunction

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
      load   = 1'b1;
      bcd_in = v;
      dp_in  = dp;
      @(negedge clk);
      load   = 1'b0;
   endtask

   task automatic capture_frame();
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         cap[i] = {digit_en, seg_out, frame_done, load_ack};
      end
   endtask

   task automatic sync_frame(output logic ack_seen, output logic found);
      found    = 1'b0;
      ack_seen = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            found    = 1'b1;
            ack_seen = load_ack;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_assert++;
         if ({digit_en, seg_out, frame_done, load_ack} !== 14'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0000", {digit_en, seg_out, frame_done, load_ack});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      logic [13:0] exp;
      int          j;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         j   = ((i - 1) % 24) + 1;
         exp = frame_exp(j, {8'hFC, 8'hFC, 8'hFC, 8'hFC}, 1'b0);
         n_assert++;
         if ({digit_en, seg_out, frame_done, load_ack} !== exp) begin
            n_fail++;
            $display("FAIL idle_scan cycle %0d: got %h, expected %h", i, {digit_en, seg_out, frame_done, load_ack}, exp);
         end
      end
   endtask

   task automatic test_load_1234();
      logic        ack;
      logic        found;
      logic [13:0] exp;
      pulse_load(16'h1234, 4'b0100);
      sync_frame(ack, found);
      n_assert++;
      if (!(found && ack === 1'b1)) begin
         n_fail++;
         $display("FAIL load_1234 ack: found=%0b ack=%b, expected found=1 ack=1", found, ack);
      end
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'h60, 8'hDB, 8'hF2, 8'h66}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL load_1234 sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_blank_lz();
      logic        ack;
      logic        found;
      logic [13:0] exp;
      blank_lz = 1'b1;
      pulse_load(16'h0007, 4'b0000);
      sync_frame(ack, found);
      n_assert++;
      if (!(found && ack === 1'b1)) begin
         n_fail++;
         $display("FAIL blank_lz ack: found=%0b ack=%b, expected found=1 ack=1", found, ack);
      end
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'h00, 8'h00, 8'h00, 8'hE4}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL blank_lz_on sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
      blank_lz = 1'b0;
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'hFC, 8'hFC, 8'hFC, 8'hE4}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL blank_lz_off sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_invalid_code();
      logic        ack;
      logic        found;
      logic [13:0] exp;
      // dp requested on the 0xA digit must still stay dark
      pulse_load(16'h00A5, 4'b0010);
      sync_frame(ack, found);
      n_assert++;
      if (!(found && ack === 1'b1)) begin
         n_fail++;
         $display("FAIL invalid_code ack: found=%0b ack=%b, expected found=1 ack=1", found, ack);
      end
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'hFC, 8'hFC, 8'h00, 8'hB6}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL invalid_code sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] exp;
      pulse_load(16'h1111, 4'b0000);
      for (int s = 2; s <= 23; s++) begin
         @(negedge clk);
         n_assert++;
         if ({frame_done, load_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL back_to_back quiet cycle %0d: got fd/ack=%b, expected 00", s, {frame_done, load_ack});
         end
         load = (s == 5) || (s == 23);
         if (s == 5) begin
            bcd_in = 16'h2222;
         end else if (s == 23) begin
            bcd_in = 16'h3333;
         end
      end
      @(negedge clk);
      load = 1'b0;
      n_assert++;
      if ({frame_done, load_ack} !== 2'b11) begin
         n_fail++;
         $display("FAIL back_to_back commit: got fd/ack=%b, expected 11", {frame_done, load_ack});
      end
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'hDA, 8'hDA, 8'hDA, 8'hDA}, 1'b1);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL back_to_back_2222 sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'hF2, 8'hF2, 8'hF2, 8'hF2}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL back_to_back_3333 sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
   endtask

   task automatic test_reset_mid_show();
      logic [13:0] exp;
      pulse_load(16'h5555, 4'b1111);
      repeat (14) @(negedge clk);
      n_assert++;
      if (digit_en !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_mid_show precondition: digit_en=%b, expected 0100", digit_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_assert++;
      if ({digit_en, seg_out, frame_done, load_ack} !== 14'h0000) begin
         n_fail++;
         $display("FAIL reset_mid_show immediate: got %h, expected 0000", {digit_en, seg_out, frame_done, load_ack});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      capture_frame();
      for (int i = 1; i <= 24; i++) begin
         exp = frame_exp(i, {8'hFC, 8'hFC, 8'hFC, 8'hFC}, 1'b0);
         n_assert++;
         if (cap[i] !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_show after sample %0d: got %h, expected %h", i, cap[i], exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load_1234();
      test_blank_lz();
      test_invalid_code();
      test_back_to_back();
      test_reset_mid_show();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
